instr_mem_responder: RTL

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

---
 rtl/instr_mem_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/instr_mem_responder.sv
// Direct-mapped, read-only instruction cache responder: hits answer the cycle after
// acceptance, misses refill a 4-word line from backing memory one word at a time.
module instr_mem_responder #(
   parameter int LINES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic        Rd,
   input  logic        Wr,
   input  logic        inv,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit,
   output logic        err,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int IDXW = $clog2(LINES);
   localparam int TAGW = 13 - IDXW;

   typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

   state_t            state_q, state_d;
   logic [15:0]       addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [1:0]        word_cnt_q, word_cnt_d;
   logic              mem_rd_q, mem_rd_d;
   logic [15:0]       mem_addr_q, mem_addr_d;
   logic              inv_pend_q, inv_pend_d;
   logic [LINES-1:0]  valid_q, valid_d;
   logic [TAGW-1:0]   tag_q [LINES];
   logic [15:0]       data_q [LINES*4];

   logic [IDXW-1:0]   idx_s;
   logic [1:0]        off_s;
   logic [TAGW-1:0]   tag_s;
   logic              bad_req_s;
   logic              hit_s;
   logic              accept_s;
   logic              fill_we_s;
   logic              fill_last_s;
   logic [1:0]        word_nxt_s;
   logic [15:0]       rd_word_s;

   assign idx_s      = addr_q[IDXW+2:3];
   assign off_s      = addr_q[2:1];
   assign tag_s      = addr_q[15:IDXW+3];
   assign bad_req_s  = wr_q | addr_q[0];
   assign hit_s      = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
   assign word_nxt_s = word_cnt_q + 2'd1;
   assign rd_word_s  = data_q[{idx_s, off_s}];
   assign mem_addr   = mem_addr_q;
   assign mem_rd     = mem_rd_q;

   // Fetch-facing status; must be combinational so a hit answers in the LOOKUP cycle.
   always_comb begin
      Done     = 1'b0;
      Stall    = 1'b0;
      CacheHit = 1'b0;
      err      = 1'b0;
      DataOut  = 16'd0;
      case (state_q)
         LOOKUP: begin
            if (bad_req_s) begin
               Done = 1'b1;
               err  = 1'b1;
            end else if (hit_s) begin
               Done     = 1'b1;
               CacheHit = 1'b1;
               DataOut  = rd_word_s;
            end else begin
               Stall = 1'b1;
            end
         end
         FILL: Stall = 1'b1;
         RESP: begin
            Done    = 1'b1;
            DataOut = rd_word_s;
         end
         default: Stall = 1'b0;
      endcase
   end

   assign accept_s = (Rd | Wr) & ~Stall & (state_q != FILL);

   // Next-state, request latch and line-fill sequencing.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wr_d        = wr_q;
      word_cnt_d  = word_cnt_q;
      mem_rd_d    = mem_rd_q;
      mem_addr_d  = mem_addr_q;
      inv_pend_d  = 1'b0;
      fill_we_s   = 1'b0;
      fill_last_s = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            if (accept_s) begin
               state_d = LOOKUP;
               addr_d  = Addr;
               wr_d    = Wr;
            end else begin
               state_d = IDLE;
            end
         end
         LOOKUP: begin
            if (bad_req_s || hit_s) begin
               if (accept_s) begin
                  state_d = LOOKUP;
                  addr_d  = Addr;
                  wr_d    = Wr;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d    = FILL;
               word_cnt_d = 2'd0;
               mem_rd_d   = 1'b1;
               mem_addr_d = {tag_s, idx_s, 2'd0, 1'b0};
               inv_pend_d = inv;
            end
         end
         FILL: begin
            // An invalidate seen anywhere in the fill keeps the new line invalid.
            inv_pend_d = inv_pend_q | inv;
            if (mem_rd_q && mem_ack) begin
               fill_we_s  = 1'b1;
               word_cnt_d = word_nxt_s;
               if (word_cnt_q == 2'd3) begin
                  fill_last_s = 1'b1;
                  mem_rd_d    = 1'b0;
                  state_d     = RESP;
               end else begin
                  mem_addr_d = {tag_s, idx_s, word_nxt_s, 1'b0};
               end
            end else begin
               fill_we_s = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Valid bits: a flush wins over a completing fill.
   always_comb begin
      valid_d = valid_q;
      if (inv) begin
         valid_d = {LINES{1'b0}};
      end else if (fill_last_s && !inv_pend_q) begin
         valid_d[idx_s] = 1'b1;
      end else begin
         valid_d = valid_q;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= 16'd0;
         wr_q       <= 1'b0;
         word_cnt_q <= 2'd0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= 16'd0;
         inv_pend_q <= 1'b0;
         valid_q    <= {LINES{1'b0}};
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wr_q       <= wr_d;
         word_cnt_q <= word_cnt_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         inv_pend_q <= inv_pend_d;
         valid_q    <= valid_d;
      end
   end

   // Tag and data storage; contents are qualified by valid_q so need no reset.
   always_ff @(posedge clk) begin
      if (fill_we_s) begin
         data_q[{idx_s, word_cnt_q}] <= mem_rdata;
      end
      if (fill_last_s) begin
         tag_q[idx_s] <= tag_s;
      end
   end

endmodule
